// File: rtl/cmpl_pkg.sv
// Shared widths, flag bit positions and the completion payload type for the completion arbiter.
package cmpl_pkg;

  localparam int unsigned ROBID_W        = 4;
  localparam int unsigned DATA_W         = 8;
  localparam int unsigned FLAG_BRANCH    = 0;
  localparam int unsigned FLAG_HALT      = 4;
  localparam int unsigned FLAG_NOT_TAKEN = 5;

  typedef struct packed {
    logic [ROBID_W-1:0] robid;
    logic [DATA_W-1:0]  flags;
    logic [DATA_W-1:0]  wbs;
    logic [DATA_W-1:0]  value;
  } cmpl_t;

endpackage

// File: rtl/cmpl_arbiter_rr.sv
// Combinational round-robin picker: first set request at or after ptr (with wrap),
// plus the pointer value that follows that grant.
module rr_arbiter #(
  parameter int unsigned NUM_FU = 4,
  localparam int unsigned PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic [NUM_FU-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NUM_FU-1:0] grant_c,
  output logic [PTR_W-1:0]  next_ptr_c
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant_c    = '0;
    next_ptr_c = ptr;
    found      = 1'b0;
    idx        = '0;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      idx = PTR_W'((32'(ptr) + k) % NUM_FU);
      if (!found && req[idx]) begin
        found        = 1'b1;
        grant_c[idx] = 1'b1;
        next_ptr_c   = PTR_W'((32'(idx) + 32'd1) % NUM_FU);
      end
    end
  end

endmodule

// File: rtl/cmpl_arbiter.sv
// Completion arbiter: per-FU holding registers, round-robin grant, registered results-buffer port.
// Define CMPL_BRANCH_PRIO_EN to search branch completions (flags[0]) ahead of all others.
module cmpl_arbiter
  import cmpl_pkg::*;
#(
  parameter int unsigned NUM_FU = 4,
  localparam int unsigned PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [NUM_FU-1:0]           fu_valid,
  output logic [NUM_FU-1:0]           fu_ready,
  input  logic [NUM_FU*ROBID_W-1:0]   fu_robid,
  input  logic [NUM_FU*DATA_W-1:0]    fu_flags,
  input  logic [NUM_FU*DATA_W-1:0]    fu_wbs,
  input  logic [NUM_FU*DATA_W-1:0]    fu_value,
  output logic                        rob_transmit,
  output logic [ROBID_W-1:0]          robid,
  output logic [DATA_W-1:0]           flags,
  output logic [DATA_W-1:0]           wbs,
  output logic [DATA_W-1:0]           value
);

  logic [NUM_FU-1:0] hold_valid_q, hold_valid_d;
  cmpl_t             hold_q [NUM_FU];
  cmpl_t             hold_d [NUM_FU];
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              rob_transmit_q, rob_transmit_d;
  cmpl_t             out_q, out_d;

  logic [NUM_FU-1:0] grant_c;
  logic [PTR_W-1:0]  next_ptr_c;
  logic [NUM_FU-1:0] hs_c;
  cmpl_t             sel_c;

`ifdef CMPL_BRANCH_PRIO_EN
  logic [NUM_FU-1:0] req_br_c, grant_br_c, grant_all_c;
  logic [PTR_W-1:0]  next_br_c, next_all_c;

  always_comb begin
    req_br_c = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      req_br_c[i] = hold_valid_q[i] && hold_q[i].flags[FLAG_BRANCH];
    end
  end

  rr_arbiter #(.NUM_FU(NUM_FU)) u_rr_br (
    .req        (req_br_c),
    .ptr        (ptr_q),
    .grant_c    (grant_br_c),
    .next_ptr_c (next_br_c)
  );

  rr_arbiter #(.NUM_FU(NUM_FU)) u_rr_all (
    .req        (hold_valid_q),
    .ptr        (ptr_q),
    .grant_c    (grant_all_c),
    .next_ptr_c (next_all_c)
  );

  // Any valid branch holder wins the cycle; otherwise plain round-robin.
  assign grant_c    = (|req_br_c) ? grant_br_c : grant_all_c;
  assign next_ptr_c = (|req_br_c) ? next_br_c  : next_all_c;
`else
  rr_arbiter #(.NUM_FU(NUM_FU)) u_rr (
    .req        (hold_valid_q),
    .ptr        (ptr_q),
    .grant_c    (grant_c),
    .next_ptr_c (next_ptr_c)
  );
`endif

  // Ready never looks at fu_valid, so there is no valid-to-ready path.
  always_comb begin
    fu_ready     = '0;
    hs_c         = '0;
    hold_valid_d = hold_valid_q;
    hold_d       = hold_q;
    sel_c        = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      fu_ready[i] = !rst && !flush && (!hold_valid_q[i] || grant_c[i]);
      hs_c[i]     = fu_valid[i] && fu_ready[i];
      if (grant_c[i]) begin
        hold_valid_d[i] = 1'b0;
        sel_c           = hold_q[i];
      end
      if (hs_c[i]) begin
        hold_valid_d[i]    = 1'b1;
        hold_d[i].robid    = fu_robid[i*ROBID_W +: ROBID_W];
        hold_d[i].flags    = fu_flags[i*DATA_W +: DATA_W];
        hold_d[i].wbs      = fu_wbs[i*DATA_W +: DATA_W];
        hold_d[i].value    = fu_value[i*DATA_W +: DATA_W];
      end
    end
    if (flush) begin
      hold_valid_d = '0;
    end
  end

  // Output stage: strobe qualifies the data, which otherwise holds its last value.
  always_comb begin
    rob_transmit_d = (|grant_c) && !flush;
    ptr_d          = ((|grant_c) && !flush) ? next_ptr_c : ptr_q;
    out_d          = (|grant_c) ? sel_c : out_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q   <= '0;
      ptr_q          <= '0;
      rob_transmit_q <= 1'b0;
      out_q          <= '0;
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      hold_valid_q   <= hold_valid_d;
      ptr_q          <= ptr_d;
      rob_transmit_q <= rob_transmit_d;
      out_q          <= out_d;
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        hold_q[i] <= hold_d[i];
      end
    end
  end

  assign rob_transmit = rob_transmit_q;
  assign robid        = out_q.robid;
  assign flags        = out_q.flags;
  assign wbs          = out_q.wbs;
  assign value        = out_q.value;

endmodule
